polar_to_cart: RTL and testbench

Fixed-point polar-to-Cartesian converter: accepts a polar sample {r, th} and produces {x, y} = {r·cos th, r·sin th} using an iterative CORDIC rotator. Consumes the packed, synthesizable form of the `{r, th}` polar struct used by the coordinate generator stage upstream. Sits directly downstream of that stage and feeds Cartesian samples to the next consumer over a valid/ready handshake. One transaction in flight at a time.

---
 rtl/polar_pkg.sv | 39 +++
 rtl/cordic_atan_lut.sv | 41 ++++
 rtl/polar_to_cart.sv | 199 +++++++++++++++++++
 tb/tb_polar_to_cart.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// Shared types and constants for the polar-to-Cartesian CORDIC converter.
package polar_pkg;

  localparam int DW_DEF = 16;

  // Constants tabulated at DW_DEF; rescale() adapts them to other widths.
  localparam int PI_Q = 25736;
  localparam int CORDIC_K = 9949;

  // Fraction bits of the tabulated arctangent entries (Q3.17, internal width 20).
  localparam int ATAN_TAB_FRAC = 17;

  typedef struct packed {
    logic signed [DW_DEF-1:0] r;
    logic signed [DW_DEF-1:0] th;
  } polar_t;

  typedef struct packed {
    logic signed [DW_DEF-1:0] x;
    logic signed [DW_DEF-1:0] y;
  } cart_t;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    ROT,
    DONE
  } p2c_state_e;

  // Move a fixed-point constant by sh fraction bits; narrowing rounds half-up.
  function automatic longint rescale(input longint v, input int sh);
    if (sh >= 0) begin
      return v <<< sh;
    end else begin
      return (v + (longint'(1) <<< (-sh - 1))) >>> (-sh);
    end
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Arctangent table: atan(2^-idx) in the internal angle format Q3.(IW-3).
module cordic_atan_lut
  import polar_pkg::*;
#(
  parameter int IW    = 20,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0]     idx,
  output logic signed [IW-1:0] atan_val
);

  logic signed [63:0] base;

  // Look up the rounded Q3.17 entry and rescale it to the requested width.
  always_comb begin
    base = 64'sd0;
    case (int'(idx))
      0:  base = 64'sd102944;
      1:  base = 64'sd60771;
      2:  base = 64'sd32110;
      3:  base = 64'sd16299;
      4:  base = 64'sd8181;
      5:  base = 64'sd4095;
      6:  base = 64'sd2048;
      7:  base = 64'sd1024;
      8:  base = 64'sd512;
      9:  base = 64'sd256;
      10: base = 64'sd128;
      11: base = 64'sd64;
      12: base = 64'sd32;
      13: base = 64'sd16;
      14: base = 64'sd8;
      15: base = 64'sd4;
      16: base = 64'sd2;
      17: base = 64'sd1;
      default: base = 64'sd0;
    endcase
    atan_val = IW'(rescale(base, (IW - 3) - ATAN_TAB_FRAC));
  end

endmodule

// File: rtl/polar_to_cart.sv
// Iterative CORDIC rotator converting {r, th} into {r*cos th, r*sin th}.
module polar_to_cart
  import polar_pkg::*;
#(
  parameter int DW   = 16,
  parameter int ITER = 16,
  parameter int GW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_th,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_x,
  output logic signed [DW-1:0] out_y
);

  localparam int IW = DW + GW;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int SH = DW - 2 - GW;

  localparam logic signed [DW-1:0] PI_DW   = DW'(rescale(longint'(PI_Q), DW - DW_DEF));
  localparam logic signed [DW-1:0] K_DW    = DW'(rescale(longint'(CORDIC_K), DW - DW_DEF));
  localparam logic signed [DW-1:0] HALF_PI = PI_DW >>> 1;
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [IW:0]   SAT_MAX_W = (IW+1)'(SAT_MAX);
  localparam logic signed [IW:0]   SAT_MIN_W = (IW+1)'(SAT_MIN);
  localparam logic signed [IW:0]   HALF_LSB  = (IW+1)'(1) <<< (GW - 1);
  localparam logic signed [2*DW-1:0] RK_RND  = (2*DW)'(1) <<< (SH - 1);

  p2c_state_e           state_q, state_d;
  logic signed [DW-1:0] r_q, r_d, th_q, th_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [CW-1:0]        i_q, i_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] out_x_q, out_x_d, out_y_q, out_y_d;

  logic signed [DW-1:0]   th_clamp;
  logic signed [IW-1:0]   th_ext, pi_ext, rk, x0, z0;
  logic signed [2*DW-1:0] r_ext, k_ext, rk_prod;
  logic signed [IW-1:0]   x_shr, y_shr, atan_i;
  logic                   d_pos;

  // Drop the guard bits with round-half-up, then saturate to DW signed.
  function automatic logic signed [DW-1:0] round_sat(input logic signed [IW-1:0] v);
    logic signed [IW:0] t;
    t = $signed({v[IW-1], v}) + HALF_LSB;
    t = t >>> GW;
    if (t > SAT_MAX_W) begin
      return SAT_MAX;
    end else if (t < SAT_MIN_W) begin
      return SAT_MIN;
    end else begin
      return DW'(t);
    end
  endfunction

  cordic_atan_lut #(
    .IW    (IW),
    .IDX_W (CW)
  ) u_atan_lut (
    .idx      (i_q),
    .atan_val (atan_i)
  );

  // Clamp the angle, fold it into the CORDIC range and form the scaled start vector.
  always_comb begin
    th_clamp = th_q;
    if (th_q > PI_DW) begin
      th_clamp = PI_DW;
    end else if (th_q < -PI_DW) begin
      th_clamp = -PI_DW;
    end
    th_ext  = {th_clamp, {GW{1'b0}}};
    pi_ext  = {PI_DW, {GW{1'b0}}};
    r_ext   = (2*DW)'(r_q);
    k_ext   = (2*DW)'(K_DW);
    rk_prod = r_ext * k_ext;
    rk      = IW'((rk_prod + RK_RND) >>> SH);
    if (th_clamp > HALF_PI) begin
      z0 = th_ext - pi_ext;
      x0 = -rk;
    end else if (th_clamp < -HALF_PI) begin
      z0 = th_ext + pi_ext;
      x0 = -rk;
    end else begin
      z0 = th_ext;
      x0 = rk;
    end
  end

  // Per-iteration shifted operands and rotation direction.
  always_comb begin
    x_shr = x_q >>> i_q;
    y_shr = y_q >>> i_q;
    d_pos = ~z_q[IW-1];
  end

  // Next-state and next-datapath logic for the IDLE/PRE/ROT/DONE sequence.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    th_d        = th_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          r_d        = in_r;
          th_d       = in_th;
          in_ready_d = 1'b0;
          state_d    = PRE;
        end
      end
      PRE: begin
        x_d     = x0;
        y_d     = '0;
        z_d     = z0;
        i_d     = '0;
        state_d = ROT;
      end
      ROT: begin
        if (d_pos) begin
          x_d = x_q - y_shr;
          y_d = y_q + x_shr;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_shr;
          y_d = y_q - x_shr;
          z_d = z_q + atan_i;
        end
        if (i_q == CW'(ITER - 1)) begin
          state_d = DONE;
        end else begin
          i_d = i_q + CW'(1);
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_x_d     = round_sat(x_q);
          out_y_d     = round_sat(y_q);
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register all state; a low rst_n aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      th_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      th_q        <= th_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      i_q         <= i_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_polar_to_cart.sv
// Directed, table-driven bench for polar_to_cart.
module tb_polar_to_cart;

  localparam int DW   = 16;
  localparam int ITER = 16;
  localparam int LAT  = ITER + 2;
  localparam int TOL  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_th;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_x;
  logic signed [DW-1:0] out_y;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string name;
    int    r;
    int    th;
    int    ex;
    int    ey;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  polar_to_cart #(
    .DW   (DW),
    .ITER (ITER),
    .GW   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_th     (in_th),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y)
  );

  // Compare with a tolerance; counts every comparison and every failure.
  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    int diff;
    total++;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", name, actual, expected, tol);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one sample once in_ready is seen; scramble inputs after the accepting edge.
  task automatic applyStimulus(input int r, input int th, output bit accepted);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      waitCycle();
      n++;
    end
    if (!in_ready) begin
      accepted = 1'b0;
    end else begin
      in_r     = r[DW-1:0];
      in_th    = th[DW-1:0];
      in_valid = 1'b1;
      waitCycle();
      in_valid = 1'b0;
      in_r     = 16'sh7abc;
      in_th    = 16'sh1357;
      accepted = 1'b1;
    end
  endtask

  // Count edges from acceptance until out_valid, bounded.
  task automatic waitValid(output int lat);
    lat = 0;
    do begin
      waitCycle();
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic runVector(input vec_t v);
    bit acc;
    int lat;
    applyStimulus(v.r, v.th, acc);
    checkOutput({v.name, " accepted"}, int'(acc), 1, 0);
    if (acc) begin
      waitValid(lat);
      checkOutput({v.name, " latency"}, lat, LAT, 0);
      checkOutput({v.name, " x"}, int'(out_x), v.ex, TOL);
      checkOutput({v.name, " y"}, int'(out_y), v.ey, TOL);
      waitCycle();
      checkOutput({v.name, " valid cleared"}, int'(out_valid), 0, 0);
      checkOutput({v.name, " in_ready after consume"}, int'(in_ready), 1, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit acc;
    int lat;
    int seen;
    vecs[0] = '{"th0",        16384,      0,  16384,      0};
    vecs[1] = '{"pi_over_2",  16384,  12868,      0,  16384};
    vecs[2] = '{"pi",         16384,  25736, -16384,      0};
    vecs[3] = '{"minus_pi_4", 16384,  -6434,  11585, -11585};
    vecs[4] = '{"r_zero",         0,   5000,      0,      0};
    vecs[5] = '{"clamp_pos",  16384,  32767, -16384,      0};
    vecs[6] = '{"clamp_neg",  16384, -32768, -16384,      0};
    vecs[7] = '{"minus_pi_2", 16384, -12868,      0, -16384};
    vecs[8] = '{"half_pi_4",   8192,   6434,   5793,   5793};
    vecs[9] = '{"pi_3",       16384,   8579,   8192,  14189};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_r      = '0;
    in_th     = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) waitCycle();
    checkOutput("reset out_valid", int'(out_valid), 0, 0);
    checkOutput("reset out_x", int'(out_x), 0, 0);
    checkOutput("reset out_y", int'(out_y), 0, 0);
    checkOutput("reset in_ready", int'(in_ready), 0, 0);
    rst_n = 1'b1;
    waitCycle();
    checkOutput("in_ready after release", int'(in_ready), 1, 0);

    for (int k = 0; k < 10; k++) begin
      runVector(vecs[k]);
    end

    // Backpressure: result held, second sample refused.
    out_ready = 1'b0;
    applyStimulus(16384, 6434, acc);
    checkOutput("bp accepted", int'(acc), 1, 0);
    waitValid(lat);
    checkOutput("bp latency", lat, LAT, 0);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_r     = 16'sd16384;
      in_th    = 16'sd0;
      checkOutput("bp x held", int'(out_x), 11585, TOL);
      checkOutput("bp y held", int'(out_y), 11585, TOL);
      checkOutput("bp out_valid held", int'(out_valid), 1, 0);
      checkOutput("bp in_ready low", int'(in_ready), 0, 0);
      waitCycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitCycle();
    checkOutput("bp consumed", int'(out_valid), 0, 0);
    checkOutput("bp in_ready next", int'(in_ready), 1, 0);
    repeat (3) waitCycle();
    checkOutput("bp second sample ignored", int'(in_ready), 1, 0);

    // Reset in the middle of the rotation phase.
    applyStimulus(16384, 0, acc);
    checkOutput("rst accepted", int'(acc), 1, 0);
    repeat (7) waitCycle();
    rst_n = 1'b0;
    waitCycle();
    checkOutput("rst in_ready low", int'(in_ready), 0, 0);
    checkOutput("rst out_valid low", int'(out_valid), 0, 0);
    rst_n = 1'b1;
    waitCycle();
    checkOutput("rst in_ready after release", int'(in_ready), 1, 0);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) seen = 1;
      waitCycle();
    end
    checkOutput("rst aborted sample silent", seen, 0, 0);
    runVector(vecs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
